bkg_ram_wr_sched: RTL and testbench
===================================

// Module: bkg_ram_wr_sched
// PURPOSE
//  Write-port scheduler for the background palette-code RAM that feeds the bar/background pixel source.
//  Shares the RAM write port between two requesters: req0 = host/bitmap loader, req1 = reel animator.
//  Round-robin arbitration with bounded bursts; optional tear-free gating so writes land only in vertical blanking.
//  Sits between the requesters and bkg_ram_unit's (we, addr_w, din); the read side is untouched.
// PARAMETERS
//  ADDR_WIDTH  20  RAM address width ({y[9:0],x[9:0]})
//  DATA_WIDTH  6   palette code width
//  MAX_BURST   16  max beats granted to one requester before re-arbitration (>=1)
// PORTS
//  clk         in   1           system clock
//  reset_n     in   1           asynchronous active-low reset
//  vblank      in   1           high during vertical blanking (already synchronous to clk)
//  gate_en     in   1           1: writes allowed only while vblank=1; 0: writes allowed any cycle
//  req0_valid  in   1           loader write request
//  req0_addr   in   ADDR_WIDTH  loader write address
//  req0_data   in   DATA_WIDTH  loader palette code
//  req0_ready  out  1           loader beat accepted this cycle (when valid & ready)
//  req1_valid/req1_addr/req1_data/req1_ready   same as req0, for the animator
//  ram_we      out  1           RAM write enable
//  ram_addr_w  out  ADDR_WIDTH  RAM write address
//  ram_din     out  DATA_WIDTH  RAM write data
//  grant_id    out  1           requester currently granted (valid while busy=1)
//  busy        out  1           state != IDLE
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE, ram_we=0, ram_addr_w=0, ram_din=0, grant_id=0, busy=0, rr_ptr=0, beat_cnt=0, req*_ready=0.
//  - window = ~gate_en | vblank.
//  - FSM:
//    - IDLE: if window and any valid, grant the requester; on tie, rr_ptr picks (rr_ptr=0 -> req0). Go to SERVE next cycle; beat_cnt=0.
//    - SERVE: reqN_ready = (grant_id==N) & window (combinational). On valid&ready, beat_cnt++.
//      Exit to IDLE when: granted valid=0; or beat_cnt reaches MAX_BURST on a handshake; or window=0.
//      On exit, rr_ptr = ~grant_id, even if the burst was cut short.
//  - Never more than one ready high per cycle. Ready is 0 in IDLE, so there is 1 arbitration bubble per grant.
//  - Write path latency 1 clk: handshake in cycle T registers addr/data and sets ram_we=1 in T+1.
//    ram_we=0 in any cycle after a non-handshake cycle.
//  - Window closing mid-burst: ready drops in the same cycle. A beat handshaken in the previous cycle still writes (in-flight beat completes).
//  - Requester dropping valid mid-burst: no penalty; the requester loses the grant.
//  - Only reset aborts an in-flight beat.
//  - Addresses are passed through unmodified. No range check; the RAM wraps natively.
// CONFIGURATION
//  BKG_FILL_EN defined: adds a rectangular-free linear fill engine that clears or paints a region.
//    - Extra ports:
//        fill_start  in   1
//        fill_base   in   ADDR_WIDTH
//        fill_len    in   ADDR_WIDTH
//        fill_code   in   DATA_WIDTH
//        fill_done   out  1  (1-clk pulse)
//    - fill_start is sampled only when no fill is pending or active; otherwise it is ignored.
//      On acceptance, base/len/code are latched into fill_pend.
//    - At the next IDLE arbitration with window=1, FILL beats both requesters.
//    - FILL: one write per window cycle, addr = base+k, mod 2^ADDR_WIDTH; pauses (no write) while window=0.
//      It is not burst-limited. grant_id holds its last value.
//    - fill_len=0 -> no writes; fill_done pulses the cycle after acceptance.
//    - Otherwise fill_done pulses in the same cycle as the final ram_we.
//  BKG_FILL_EN undefined: no fill ports, no FILL state; the block is a pure 2-way scheduler.
// TESTING
//  1. Reset mid-burst: reset_n=0 at an arbitrary cycle -> all outputs 0 in that cycle (async), no further ram_we.
//  2. gate_en=0, req0 streams 20 beats with addr 0x00000..0x00013 -> 16 writes, then IDLE bubble.
//     req1 (if valid) granted next; otherwise req0 resumes with beats 0x10..0x13; each write 1 clk after its handshake.
//  3. Both valid continuously, MAX_BURST=16, gate_en=0 -> grants alternate 0,1,0,1 in 16-beat bursts; no cycle with both ready=1.
//  4. gate_en=1, vblank=0, req1 valid -> ready=0 and no writes.
//     Raise vblank for 5 clks -> IDLE + 4 beats written; ready drops the same cycle vblank falls.
//  5. req0 drops valid after 3 beats while req1 is waiting -> req1 granted after 1 bubble; rr_ptr=0 afterwards.
//  6. (BKG_FILL_EN) fill_base=0xFFFFE, fill_len=4, fill_code=6'h27, gate_en=0.
//     Expect writes to 0xFFFFE, 0xFFFFF, 0x00000, 0x00001; fill_done with the last write.
//     Then fill_len=0 -> done pulse only, no ram_we.

Source files
------------

// File: rtl/bkg_ram_wr_sched.sv
// bkg_ram_wr_sched: shares the background palette-code RAM write port
// between the bitmap loader (req0) and the reel animator (req1).
//
// Round-robin arbitration with bursts of at most MAX_BURST beats.
// Writes can be held back to vertical blanking (tear-free gating).
// The write path is registered: a beat accepted in cycle T is written
// in cycle T+1.
//
// Build option: define BKG_FILL_EN to add a linear fill engine
// (fill_start/fill_base/fill_len/fill_code in, fill_done out).
//
// Ports:
//   clk, reset_n          clock, async active-low reset
//   vblank, gate_en       write window = ~gate_en | vblank
//   reqN_valid/addr/data  requester N write beat
//   reqN_ready            beat N accepted when valid & ready
//   ram_we/addr_w/din     RAM write port
//   grant_id, busy        current owner (valid while busy), FSM busy
module bkg_ram_wr_sched #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 6,
    parameter int MAX_BURST  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vblank,
    input  logic                  gate_en,
`ifdef BKG_FILL_EN
    input  logic                  fill_start,
    input  logic [ADDR_WIDTH-1:0] fill_base,
    input  logic [ADDR_WIDTH-1:0] fill_len,
    input  logic [DATA_WIDTH-1:0] fill_code,
    output logic                  fill_done,
`endif
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic                  grant_id,
    output logic                  busy
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(MAX_BURST - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        FILL  = 2'd2
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    grant_d;
    logic                    rr_ptr;
    logic                    rr_d;
    logic [BW-1:0]           beat_cnt;
    logic [BW-1:0]           beat_d;
    logic                    we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   din_d;

    logic                    window;
    logic                    any_valid;
    logic                    pick;
    logic                    g_valid;
    logic                    hs;
    logic                    fill_req;

    assign window    = ~gate_en | vblank;
    assign any_valid = req0_valid | req1_valid;
    // On a tie the round-robin pointer decides; otherwise the lone requester.
    assign pick      = (req0_valid & req1_valid) ? rr_ptr : req1_valid;
    assign g_valid   = grant_id ? req1_valid : req0_valid;
    assign hs        = (state_q == SERVE) & g_valid & window;
    assign busy      = (state_q != IDLE);

`ifdef BKG_FILL_EN
    logic                    fill_pend;
    logic                    fill_accept;
    logic                    fill_step;
    logic                    fill_last;
    logic [ADDR_WIDTH-1:0]   fill_addr;
    logic [ADDR_WIDTH-1:0]   fill_rem;
    logic [DATA_WIDTH-1:0]   fill_code_q;

    // fill_pend stays high until the last fill write, so it also covers
    // the active phase: a new start is ignored while either is true.
    assign fill_accept = fill_start & ~fill_pend;
    assign fill_step   = (state_q == FILL) & window;
    assign fill_last   = fill_step & (fill_rem == ADDR_WIDTH'(1));
    assign fill_req    = fill_pend;
`else
    assign fill_req    = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_id;
        rr_d       = rr_ptr;
        beat_d     = beat_cnt;
        we_d       = 1'b0;
        addr_d     = ram_addr_w;
        din_d      = ram_din;
        req0_ready = 1'b0;
        req1_ready = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (window) begin
                    if (fill_req) begin
                        state_d = FILL;
                    end else if (any_valid) begin
                        state_d = SERVE;
                        grant_d = pick;
                        beat_d  = '0;
                    end
                end
            end

            SERVE: begin
                req0_ready = ~grant_id & window;
                req1_ready = grant_id & window;
                if (hs) begin
                    beat_d = beat_cnt + BW'(1);
                    we_d   = 1'b1;
                    addr_d = grant_id ? req1_addr : req0_addr;
                    din_d  = grant_id ? req1_data : req0_data;
                end
                // A cut-short burst still hands priority to the other side.
                if (~g_valid | ~window | (hs & (beat_cnt == LAST_BEAT))) begin
                    state_d = IDLE;
                    rr_d    = ~grant_id;
                end
            end

`ifdef BKG_FILL_EN
            FILL: begin
                if (fill_step) begin
                    we_d   = 1'b1;
                    addr_d = fill_addr;
                    din_d  = fill_code_q;
                    if (fill_last) begin
                        state_d = IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_id   <= 1'b0;
            rr_ptr     <= 1'b0;
            beat_cnt   <= '0;
            ram_we     <= 1'b0;
            ram_addr_w <= '0;
            ram_din    <= '0;
        end else begin
            state_q    <= state_d;
            grant_id   <= grant_d;
            rr_ptr     <= rr_d;
            beat_cnt   <= beat_d;
            ram_we     <= we_d;
            ram_addr_w <= addr_d;
            ram_din    <= din_d;
        end
    end

`ifdef BKG_FILL_EN
    // fill_done is registered like ram_we so it coincides with the
    // final write; a zero-length fill pulses it right after acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill_pend   <= 1'b0;
            fill_addr   <= '0;
            fill_rem    <= '0;
            fill_code_q <= '0;
            fill_done   <= 1'b0;
        end else begin
            fill_done <= 1'b0;
            if (fill_accept) begin
                fill_addr   <= fill_base;
                fill_rem    <= fill_len;
                fill_code_q <= fill_code;
                fill_pend   <= (fill_len != '0);
                fill_done   <= (fill_len == '0);
            end else if (fill_step) begin
                fill_addr <= fill_addr + ADDR_WIDTH'(1);
                fill_rem  <= fill_rem - ADDR_WIDTH'(1);
                if (fill_last) begin
                    fill_pend <= 1'b0;
                    fill_done <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_bkg_ram_wr_sched.sv
// Bench for bkg_ram_wr_sched: directed scenarios plus random traffic,
// every cycle compared against a transaction-level arbiter model.
module tb_bkg_ram_wr_sched;

    localparam int AW = 20;
    localparam int DW = 6;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          vblank = 1'b0;
    logic          gate_en = 1'b0;
    logic          req0_valid = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req0_ready;
    logic          req1_valid = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic          req1_ready;
    logic          ram_we;
    logic [AW-1:0] ram_addr_w;
    logic [DW-1:0] ram_din;
    logic          grant_id;
    logic          busy;
`ifdef BKG_FILL_EN
    logic          fill_start = 1'b0;
    logic [AW-1:0] fill_base = '0;
    logic [AW-1:0] fill_len = '0;
    logic [DW-1:0] fill_code = '0;
    logic          fill_done;
`endif

    bkg_ram_wr_sched #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vblank    (vblank),
        .gate_en   (gate_en),
`ifdef BKG_FILL_EN
        .fill_start(fill_start),
        .fill_base (fill_base),
        .fill_len  (fill_len),
        .fill_code (fill_code),
        .fill_done (fill_done),
`endif
        .req0_valid(req0_valid),
        .req0_addr (req0_addr),
        .req0_data (req0_data),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_addr (req1_addr),
        .req1_data (req1_data),
        .req1_ready(req1_ready),
        .ram_we    (ram_we),
        .ram_addr_w(ram_addr_w),
        .ram_din   (ram_din),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;
    bit chk_en = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cyc %0d)",
                      name, act, exp, cyc);
    endtask

    // Observed writes, for the directed literal checks.
    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } log_t;
    log_t wlog[$];
    int   dlog[$];

    // Reference model: who owns the port, how many beats it has used,
    // whose turn it is on a tie, and the writes owed to the RAM.
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;
    bit  m_busy = 1'b0;
    bit  m_owner = 1'b0;
    bit  m_rr = 1'b0;
    int  m_beats = 0;
    wr_t m_q[$];

    task automatic model_cycle();
        bit            win;
        bit            v[2];
        logic [AW-1:0] a[2];
        logic [DW-1:0] d[2];
        bit            er[2];
        wr_t           w;
        if (!reset_n) begin
            m_busy = 0; m_owner = 0; m_rr = 0; m_beats = 0;
            m_q.delete();
            chk("rst busy", busy, 0);
            chk("rst we", ram_we, 0);
            chk("rst addr", ram_addr_w, 0);
            chk("rst din", ram_din, 0);
            chk("rst grant", grant_id, 0);
            chk("rst rdy0", req0_ready, 0);
            chk("rst rdy1", req1_ready, 0);
            return;
        end
        win  = !gate_en || vblank;
        v[0] = req0_valid; v[1] = req1_valid;
        a[0] = req0_addr;  a[1] = req1_addr;
        d[0] = req0_data;  d[1] = req1_data;
        er[0] = m_busy && !m_owner && win;
        er[1] = m_busy && m_owner && win;
        chk("ready0", req0_ready, er[0]);
        chk("ready1", req1_ready, er[1]);
        chk("busy", busy, m_busy);
        if (m_busy) chk("grant", grant_id, m_owner);
        if (m_q.size() > 0) begin
            w = m_q.pop_front();
            chk("we", ram_we, 1);
            chk("addr", ram_addr_w, w.a);
            chk("din", ram_din, w.d);
        end else begin
            chk("we idle", ram_we, 0);
        end
        if (m_busy) begin
            if (er[m_owner] && v[m_owner]) begin
                m_q.push_back('{a[m_owner], d[m_owner]});
                m_beats++;
            end
            if (!v[m_owner] || !win || m_beats == MB) begin
                m_busy = 0;
                m_rr   = !m_owner;
            end
        end else if (win && (v[0] || v[1])) begin
            m_owner = (v[0] && v[1]) ? m_rr : v[1];
            m_busy  = 1;
            m_beats = 0;
        end
    endtask

    always @(negedge clk) begin
        if (ram_we) wlog.push_back('{cyc, ram_addr_w, ram_din});
`ifdef BKG_FILL_EN
        if (fill_done) dlog.push_back(cyc);
`endif
        if (chk_en) model_cycle();
    end

    task automatic set_req(input bit w, input bit v, input logic [AW-1:0] a);
        if (w) begin
            req1_valid = v; req1_addr = a; req1_data = a[DW-1:0] ^ 6'h2A;
        end else begin
            req0_valid = v; req0_addr = a; req0_data = a[DW-1:0] ^ 6'h15;
        end
    endtask

    // Stream n beats on one port, address base+k for the k-th beat.
    task automatic beats(input bit w, input int n, input logic [AW-1:0] base);
        int k = 0;
        int g = 0;
        set_req(w, 1'b1, base);
        while (k < n && g < 500) begin
            @(negedge clk);
            if (w ? (req1_valid && req1_ready) : (req0_valid && req0_ready)) k++;
            @(posedge clk); #1;
            g++;
            set_req(w, 1'b1, base + AW'(k));
        end
        set_req(w, 1'b0, base + AW'(k));
        if (k < n) begin
            n_tot++;
            $display("FAIL beats timeout: got %0d beats, want %0d", k, n);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("init busy", busy, 0);
        chk("init we", ram_we, 0);
        chk("init grant", grant_id, 0);
        chk("init rdy0", req0_ready, 0);
        chk("init addr", ram_addr_w, 0);

        // Both requesters saturating: 16-beat bursts alternating 0,1,0,1.
        reset_n = 1'b1;
        set_req(0, 1'b1, 20'h0000A);
        set_req(1, 1'b1, 20'h1000B);
        wlog.delete();
        repeat (60) @(posedge clk);
        #1;
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("rr count", wlog.size(), 56);
        chk("rr w0", wlog[0].a, 20'h0000A);
        chk("rr w15", wlog[15].a, 20'h0000A);
        chk("rr w16", wlog[16].a, 20'h1000B);
        chk("rr w16 din", wlog[16].d, 6'h21);
        chk("rr bubble", wlog[16].c - wlog[15].c, 2);
        chk("rr w32", wlog[32].a, 20'h0000A);
        chk("rr w48", wlog[48].a, 20'h1000B);

        // Reset mid-burst: outputs clear at once, no write follows.
        set_req(0, 1'b1, 20'h00055);
        set_req(1, 1'b1, 20'h00066);
        repeat (7) @(posedge clk);
        #3 reset_n = 1'b0;
        wlog.delete();
        #1;
        chk("amid busy", busy, 0);
        chk("amid we", ram_we, 0);
        chk("amid addr", ram_addr_w, 0);
        chk("amid rdy", {req0_ready, req1_ready}, 0);
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        @(posedge clk); #1 reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("amid no wr", wlog.size(), 0);

        // Single requester, 20 beats: 16, one bubble, then 4 more.
        wlog.delete();
        beats(0, 20, 20'h00000);
        repeat (3) @(posedge clk);
        #1;
        chk("s20 count", wlog.size(), 20);
        chk("s20 w15", wlog[15].a, 20'h0000F);
        chk("s20 w16", wlog[16].a, 20'h00010);
        chk("s20 w19", wlog[19].a, 20'h00013);
        chk("s20 din5", wlog[5].d, 6'h10);
        chk("s20 back2back", wlog[1].c - wlog[0].c, 1);
        chk("s20 bubble", wlog[16].c - wlog[15].c, 2);

        // Gated: nothing outside vblank; 5 vblank cycles give 4 beats.
        gate_en = 1'b1;
        vblank  = 1'b0;
        wlog.delete();
        set_req(1, 1'b1, 20'h02345);
        repeat (4) @(posedge clk);
        #1;
        chk("gate rdy", req1_ready, 0);
        vblank = 1'b1;
        repeat (5) @(posedge clk);
        #1 vblank = 1'b0;
        #1;
        chk("gate drop rdy", req1_ready, 0);
        chk("gate drop busy", busy, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("gate count", wlog.size(), 4);
        chk("gate span", wlog[3].c - wlog[0].c, 3);
        set_req(1, 1'b0, '0);
        gate_en = 1'b0;

        // req0 quits after 3 beats while req1 waits.
        do_reset();
        wlog.delete();
        set_req(1, 1'b1, 20'h00200);
        beats(0, 3, 20'h00100);
        beats(1, 5, 20'h00200);
        repeat (3) @(posedge clk);
        #1;
        set_req(1, 1'b1, 20'h00400);
        beats(0, 1, 20'h00300);
        set_req(1, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        chk("drop w2", wlog[2].a, 20'h00102);
        chk("drop w3", wlog[3].a, 20'h00200);
        chk("drop gap", wlog[3].c - wlog[2].c, 3);
        chk("drop rr", wlog[8].a, 20'h00300);

        // Random traffic against the model.
        for (int i = 0; i < 2500; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(5) == 0) req0_valid = ~req0_valid;
            if ($urandom_range(5) == 0) req1_valid = ~req1_valid;
            req0_addr = AW'($urandom);
            req0_data = DW'($urandom);
            req1_addr = AW'($urandom);
            req1_data = DW'($urandom);
            if ($urandom_range(49) == 0) gate_en = ~gate_en;
            if ($urandom_range(7) == 0) vblank = ~vblank;
            if ($urandom_range(799) == 0) begin
                #2 reset_n = 1'b0;
                @(posedge clk); #1 reset_n = 1'b1;
            end
        end

`ifdef BKG_FILL_EN
        set_req(0, 1'b0, '0);
        set_req(1, 1'b0, '0);
        gate_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk_en = 1'b0;
        wlog.delete();
        dlog.delete();
        fill_base  = 20'hFFFFE;
        fill_len   = 20'd4;
        fill_code  = 6'h27;
        fill_start = 1'b1;
        @(posedge clk); #1 fill_start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("fill count", wlog.size(), 4);
        chk("fill a0", wlog[0].a, 20'hFFFFE);
        chk("fill a1", wlog[1].a, 20'hFFFFF);
        chk("fill a2", wlog[2].a, 20'h00000);
        chk("fill a3", wlog[3].a, 20'h00001);
        chk("fill code", wlog[3].d, 6'h27);
        chk("fill done n", dlog.size(), 1);
        chk("fill done cyc", dlog[0], wlog[3].c);
        begin
            int t0;
            wlog.delete();
            dlog.delete();
            fill_len   = '0;
            fill_start = 1'b1;
            t0 = cyc;
            @(posedge clk); #1 fill_start = 1'b0;
            repeat (4) @(posedge clk);
            #1;
            chk("fill0 no wr", wlog.size(), 0);
            chk("fill0 done n", dlog.size(), 1);
            chk("fill0 done cyc", dlog[0], t0 + 1);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
